// File: rtl/spi_xfer_sequencer.sv
// Byte-stream sequencer in front of the single-byte SPI driver: TX FIFO -> driver launch -> RX FIFO.
// Latency: one cycle from TX FIFO non-empty to drv_start; rx_valid rises one cycle after driver completion.
// Backpressure: tx_ready drops when the TX FIFO is full; launches stall while the RX FIFO has no free slot.

module spi_xfer_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    localparam logic [AW:0] DEPTH_LVL = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Storage, pointers and occupancy; callers never push when full or pop when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            if (push && !pop) begin
                level <= level + (AW+1)'(1);
            end else if (pop && !push) begin
                level <= level - (AW+1)'(1);
            end
        end
    end

    // Head of queue is read straight out of the register array.
    assign rdata = mem[rptr];
    assign full  = (level == DEPTH_LVL);
    assign empty = (level == '0);
endmodule

module spi_xfer_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [7:0]               drv_data_in,
    output logic                     drv_start,
    input  logic                     drv_en,
    input  logic [7:0]               drv_data_out,
    output logic [$clog2(DEPTH):0]   tx_level,
    output logic [$clog2(DEPTH):0]   rx_level,
    output logic                     busy,
    output logic [15:0]              xfer_count
);
    typedef enum logic [1:0] {IDLE, START, WAIT_LOW, WAIT_HIGH} state_t;

    state_t     state;
    logic       tx_full;
    logic       tx_empty;
    logic       rx_full;
    logic       rx_empty;
    logic       tx_push;
    logic       rx_push;
    logic       rx_pop;
    logic       launch;
    logic [7:0] tx_head;

    // Accept only on a free slot; full blocks even if a launch pops in the same cycle.
    assign tx_ready = !tx_full;
    assign tx_push  = tx_valid && !tx_full;

    // A launch needs a byte to send and a free RX slot reserved for the reply.
    assign launch   = (state == IDLE) && !tx_empty && !rx_full;

    // Completion is the first cycle the driver releases chip-enable after we saw it low.
    assign rx_push  = (state == WAIT_HIGH) && drv_en;
    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;

    assign busy     = (state != IDLE) || !tx_empty;

    spi_xfer_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (launch),
        .wdata (tx_data),
        .rdata (tx_head),
        .level (tx_level),
        .full  (tx_full),
        .empty (tx_empty)
    );

    spi_xfer_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .wdata (drv_data_out),
        .rdata (rx_data),
        .level (rx_level),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Transfer FSM: drv_start is high exactly in START and WAIT_LOW, so the driver
    // sees it in its idle state and it is gone before the driver can return to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            drv_start   <= 1'b0;
            drv_data_in <= 8'h00;
            xfer_count  <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        drv_data_in <= tx_head;
                        drv_start   <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    drv_start <= 1'b1;
                    state     <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!drv_en) begin
                        drv_start <= 1'b0;
                        state     <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    drv_start <= 1'b0;
                    if (drv_en) begin
                        xfer_count <= xfer_count + 16'd1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    drv_start <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Bench for spi_xfer_sequencer with a behavioural SPI driver model (optional MISO xor mask).
// Table of single-byte transfers plus hand sequences: timing, burst, stall, TX full, reset, wrap.
// Inputs driven and outputs sampled on the falling clock edge.

module tb_spi_xfer_sequencer;
    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] drv_data_in;
    logic       drv_start;
    logic       drv_en;
    logic [7:0] drv_data_out;
    logic [2:0] tx_level;
    logic [2:0] rx_level;
    logic       busy;
    logic [15:0] xfer_count;

    int errors = 0;
    int checks = 0;

    spi_xfer_sequencer #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .drv_data_in  (drv_data_in),
        .drv_start    (drv_start),
        .drv_en       (drv_en),
        .drv_data_out (drv_data_out),
        .tx_level     (tx_level),
        .rx_level     (rx_level),
        .busy         (busy),
        .xfer_count   (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver model: idle -> shifting (chip-enable low) -> cleanup -> idle.
    logic [7:0] miso_xor = 8'h00;
    logic [1:0] m_st;
    int         m_cnt;
    logic [7:0] m_sh;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_en       <= 1'b1;
            drv_data_out <= 8'h00;
            m_st         <= 2'd0;
            m_cnt        <= 0;
            m_sh         <= 8'h00;
        end else begin
            case (m_st)
                2'd0: if (drv_start) begin
                    m_sh   <= drv_data_in;
                    drv_en <= 1'b0;
                    m_cnt  <= 0;
                    m_st   <= 2'd1;
                end
                2'd1: if (m_cnt == 6) begin
                    drv_en       <= 1'b1;
                    drv_data_out <= m_sh ^ miso_xor;
                    m_st         <= 2'd2;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
                default: m_st <= 2'd0;
            endcase
        end
    end

    // Monitor: launched bytes, consumed RX bytes, shortest drv_start pulse.
    logic [7:0] launch_q[$];
    logic [7:0] rx_q[$];
    logic       prev_start = 1'b0;
    int         start_run = 0;
    int         min_run = 1000;
    always @(posedge clk) begin
        if (rst_n) begin
            if (drv_start && !prev_start) launch_q.push_back(drv_data_in);
            if (rx_valid && rx_ready) rx_q.push_back(rx_data);
            if (drv_start) begin
                start_run = start_run + 1;
            end else if (start_run > 0) begin
                if (start_run < min_run) min_run = start_run;
                start_run = 0;
            end
            prev_start = drv_start;
        end else begin
            prev_start = 1'b0;
            start_run  = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("push_timeout", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rx(input string name);
        int n = 0;
        while (rx_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_rx_valid"}, {31'd0, rx_valid}, 32'd1);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  tx;
        logic [7:0]  mask;
        logic [7:0]  exp_rx;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n;
        vecs[0] = '{8'h00, 8'h00, 8'h00, 16'd2};
        vecs[1] = '{8'hFF, 8'h00, 8'hFF, 16'd3};
        vecs[2] = '{8'h3C, 8'hFF, 8'hC3, 16'd4};
        vecs[3] = '{8'h81, 8'h0F, 8'h8E, 16'd5};
        vecs[4] = '{8'h96, 8'hA5, 8'h33, 16'd6};

        rst_n    = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'h00);
        check("rst_tx_level", {29'd0, tx_level}, 32'd0);
        check("rst_rx_level", {29'd0, rx_level}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_xfer_count", {16'd0, xfer_count}, 32'd0);
        check("rst_drv_start", {31'd0, drv_start}, 32'd0);
        check("rst_drv_data_in", {24'd0, drv_data_in}, 32'h00);

        // Single 0xA5 loopback with cycle-level timing
        push(8'hA5);
        check("a5_tx_level_after_push", {29'd0, tx_level}, 32'd1);
        check("a5_start_low_e0", {31'd0, drv_start}, 32'd0);
        check("a5_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("a5_start_high_e1", {31'd0, drv_start}, 32'd1);
        check("a5_drv_data_in", {24'd0, drv_data_in}, 32'hA5);
        check("a5_tx_level_popped", {29'd0, tx_level}, 32'd0);
        n = 0;
        while (drv_en !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        check("a5_drv_en_low", {31'd0, drv_en}, 32'd0);
        n = 0;
        while (drv_en !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("a5_drv_en_high", {31'd0, drv_en}, 32'd1);
        check("a5_rx_valid_not_yet", {31'd0, rx_valid}, 32'd0);
        check("a5_start_low_done", {31'd0, drv_start}, 32'd0);
        @(negedge clk);
        check("a5_rx_valid", {31'd0, rx_valid}, 32'd1);
        check("a5_rx_data", {24'd0, rx_data}, 32'hA5);
        check("a5_xfer_count", {16'd0, xfer_count}, 32'd1);
        check("a5_rx_level", {29'd0, rx_level}, 32'd1);
        check("a5_busy_idle", {31'd0, busy}, 32'd0);
        check("a5_launches", launch_q.size(), 32'd1);
        pop_one();
        check("a5_rx_valid_after_pop", {31'd0, rx_valid}, 32'd0);

        // Table of single transfers with varying MISO masks
        for (int i = 0; i < 5; i++) begin
            miso_xor = vecs[i].mask;
            push(vecs[i].tx);
            wait_rx($sformatf("vec%0d", i));
            check($sformatf("vec%0d_rx_data", i), {24'd0, rx_data}, {24'd0, vecs[i].exp_rx});
            check($sformatf("vec%0d_drv_data_in", i), {24'd0, drv_data_in}, {24'd0, vecs[i].tx});
            check($sformatf("vec%0d_xfer_count", i), {16'd0, xfer_count}, {16'd0, vecs[i].exp_cnt});
            check($sformatf("vec%0d_rx_level", i), {29'd0, rx_level}, 32'd1);
            pop_one();
            check($sformatf("vec%0d_rx_empty", i), {31'd0, rx_valid}, 32'd0);
        end
        miso_xor = 8'h00;

        // Burst 01..04 with rx_ready held high
        launch_q.delete();
        rx_q.delete();
        rx_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push(8'(i));
        n = 0;
        while ((busy !== 1'b0 || xfer_count !== 16'd10) && n < 500) begin @(negedge clk); n++; end
        @(negedge clk);
        rx_ready = 1'b0;
        check("burst_xfer_count", {16'd0, xfer_count}, 32'd10);
        check("burst_busy", {31'd0, busy}, 32'd0);
        check("burst_rx_count", rx_q.size(), 32'd4);
        check("burst_launch_count", launch_q.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rx_q.size()) check($sformatf("burst_rx%0d", i), {24'd0, rx_q[i]}, i + 1);
            if (i < launch_q.size()) check($sformatf("burst_launch%0d", i), {24'd0, launch_q[i]}, i + 1);
        end

        // Stall: RX never drained, six bytes pushed
        launch_q.delete();
        rx_q.delete();
        for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
        repeat (150) @(negedge clk);
        check("stall_xfer_count", {16'd0, xfer_count}, 32'd14);
        check("stall_rx_level", {29'd0, rx_level}, 32'd4);
        check("stall_tx_level", {29'd0, tx_level}, 32'd2);
        check("stall_drv_start", {31'd0, drv_start}, 32'd0);
        check("stall_busy", {31'd0, busy}, 32'd1);
        check("stall_rx_head", {24'd0, rx_data}, 32'h10);

        // TX full while stalled
        push(8'h16);
        push(8'h17);
        check("full_tx_level", {29'd0, tx_level}, 32'd4);
        check("full_tx_ready", {31'd0, tx_ready}, 32'd0);
        tx_data  = 8'h18;
        tx_valid = 1'b1;
        repeat (5) @(negedge clk);
        tx_valid = 1'b0;
        check("full_5th_rejected", {29'd0, tx_level}, 32'd4);

        // Release RX: everything drains in order
        rx_ready = 1'b1;
        n = 0;
        while ((busy !== 1'b0 || rx_valid !== 1'b0) && n < 1000) begin @(negedge clk); n++; end
        rx_ready = 1'b0;
        check("drain_xfer_count", {16'd0, xfer_count}, 32'd18);
        check("drain_rx_count", rx_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < rx_q.size()) check($sformatf("drain_rx%0d", i), {24'd0, rx_q[i]}, 32'h10 + i);
        end

        // Reset in WAIT_HIGH
        push(8'h77);
        n = 0;
        while ((drv_en !== 1'b0 || drv_start !== 1'b0) && n < 50) begin @(negedge clk); n++; end
        check("midrst_in_wait_high", {30'd0, drv_en, drv_start}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_drv_start", {31'd0, drv_start}, 32'd0);
        check("midrst_drv_data_in", {24'd0, drv_data_in}, 32'h00);
        check("midrst_xfer_count", {16'd0, xfer_count}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_levels", {26'd0, tx_level, rx_level}, 32'd0);
        check("midrst_ready_valid", {30'd0, tx_ready, rx_valid}, 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(8'h3C);
        wait_rx("post_rst");
        check("post_rst_rx_data", {24'd0, rx_data}, 32'h3C);
        check("post_rst_xfer_count", {16'd0, xfer_count}, 32'd1);
        check("post_rst_rx_level", {29'd0, rx_level}, 32'd1);
        pop_one();

        // Counter wrap
        force dut.xfer_count = 16'hFFFF;
        #1;
        release dut.xfer_count;
        @(negedge clk);
        check("wrap_preload", {16'd0, xfer_count}, 32'hFFFF);
        push(8'h5A);
        wait_rx("wrap");
        check("wrap_xfer_count", {16'd0, xfer_count}, 32'h0000);
        check("wrap_rx_data", {24'd0, rx_data}, 32'h5A);
        pop_one();

        check("start_min_width_ge2", {31'd0, (min_run >= 2)}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
